// File: rtl/i2c_init_sequencer_pkg.sv
// Shared definitions for the I2C init sequencer: state encoding, table word
// layout and index width.
package i2c_init_sequencer_pkg;

    localparam int IDX_W       = 8;
    localparam int TD_W        = 23;
    localparam int TD_ADDR_LSB = 16;
    localparam int TD_REG_LSB  = 8;
    localparam int TD_DATA_LSB = 0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_STARTUP,
        ST_FETCH,
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT,
        ST_RETRY,
        ST_DONE,
        ST_ERROR
    } state_e;

    typedef struct packed {
        logic [6:0] addr;
        logic [7:0] regaddr;
        logic [7:0] data;
    } entry_t;

    function automatic entry_t td_unpack(input logic [TD_W-1:0] td);
        entry_t e;
        e.addr    = td[TD_ADDR_LSB +: 7];
        e.regaddr = td[TD_REG_LSB  +: 8];
        e.data    = td[TD_DATA_LSB +: 8];
        return e;
    endfunction

endpackage

// File: rtl/i2c_init_sequencer_if.sv
// Host + I2C-master facing signals of the init sequencer; the master modport
// is the sequencer's view, the slave modport the surrounding logic's view.
interface i2c_init_sequencer_if;
    import i2c_init_sequencer_pkg::*;

    logic             start;
    logic             busy;
    logic             done;
    logic             error;
    logic [IDX_W-1:0] error_index;
    logic [IDX_W-1:0] table_index;
    logic             i2c_ready;
    logic [6:0]       i2c_address;
    logic             i2c_rw;
    logic [7:0]       i2c_register;
    logic [7:0]       i2c_data;
    logic             i2c_valid;
    logic             i2c_ack;

    modport master (
        input  start, i2c_valid, i2c_ack,
        output busy, done, error, error_index, table_index,
               i2c_ready, i2c_address, i2c_rw, i2c_register, i2c_data
    );

    modport slave (
        output start, i2c_valid, i2c_ack,
        input  busy, done, error, error_index, table_index,
               i2c_ready, i2c_address, i2c_rw, i2c_register, i2c_data
    );

endinterface

// File: rtl/i2c_init_table.sv
// Registered init ROM: data_o holds the entry addressed by index_i one cycle
// earlier. Contents arrive through TABLE_INIT, entry i at bits [i*23 +: 23].
module i2c_init_table
    import i2c_init_sequencer_pkg::*;
#(
    parameter int                          ENTRY_COUNT = 16,
    parameter logic [ENTRY_COUNT*TD_W-1:0] TABLE_INIT  = '0
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic [IDX_W-1:0] index_i,
    output logic [TD_W-1:0]  data_o
);

    logic [TD_W-1:0] data_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            data_q <= '0;
        end else begin
            data_q <= TABLE_INIT[int'(index_i) * TD_W +: TD_W];
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/i2c_init_sequencer.sv
// Walks the init table, issuing one I2C write per entry, retrying NACKed
// entries after an idle gap and stopping in DONE or ERROR.
module i2c_init_sequencer
    import i2c_init_sequencer_pkg::*;
#(
    parameter int                          ENTRY_COUNT   = 16,
    parameter int                          RETRY_LIMIT   = 3,
    parameter int                          RETRY_DELAY   = 1000,
    parameter int                          STARTUP_DELAY = 0,
    parameter logic [ENTRY_COUNT*TD_W-1:0] TABLE_INIT    = '0
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    i2c_init_sequencer_if.master  bus
);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(ENTRY_COUNT - 1);
    localparam logic [3:0]       RETRY_MAX = 4'(RETRY_LIMIT);

    state_e           state_q,   state_d;
    logic [31:0]      delay_q,   delay_d;
    logic [3:0]       retry_q,   retry_d;
    logic [IDX_W-1:0] index_q,   index_d;
    logic [IDX_W-1:0] err_idx_q, err_idx_d;
    logic [6:0]       addr_q,    addr_d;
    logic [7:0]       reg_q,     reg_d;
    logic [7:0]       data_q,    data_d;

    logic [TD_W-1:0]  table_data;
    entry_t           entry;

    i2c_init_table #(
        .ENTRY_COUNT (ENTRY_COUNT),
        .TABLE_INIT  (TABLE_INIT)
    ) u_table (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .index_i (index_q),
        .data_o  (table_data)
    );

    assign entry = td_unpack(table_data);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            delay_q   <= '0;
            retry_q   <= '0;
            index_q   <= '0;
            err_idx_q <= '0;
            addr_q    <= '0;
            reg_q     <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            delay_q   <= delay_d;
            retry_q   <= retry_d;
            index_q   <= index_d;
            err_idx_q <= err_idx_d;
            addr_q    <= addr_d;
            reg_q     <= reg_d;
            data_q    <= data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        delay_d   = delay_q;
        retry_d   = retry_q;
        index_d   = index_q;
        err_idx_d = err_idx_q;
        addr_d    = addr_q;
        reg_d     = reg_q;
        data_d    = data_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (bus.start) begin
                    index_d = '0;
                    retry_d = '0;
                    if (STARTUP_DELAY == 0) begin
                        state_d = ST_FETCH;
                    end else begin
                        delay_d = 32'(STARTUP_DELAY - 1);
                        state_d = ST_STARTUP;
                    end
                end
            end
            ST_STARTUP: begin
                if (delay_q == 32'd0) state_d = ST_FETCH;
                else                  delay_d = delay_q - 32'd1;
            end
            // The ROM sees index_q during FETCH and presents the word in LOAD.
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD: begin
                addr_d  = entry.addr;
                reg_d   = entry.regaddr;
                data_d  = entry.data;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (bus.i2c_valid) begin
                    if (!bus.i2c_ack) begin
                        if (index_q == LAST_IDX) begin
                            state_d = ST_DONE;
                        end else begin
                            index_d = index_q + 8'd1;
                            retry_d = '0;
                            state_d = ST_FETCH;
                        end
                    end else if (retry_q != RETRY_MAX) begin
                        retry_d = retry_q + 4'd1;
                        delay_d = 32'(RETRY_DELAY - 1);
                        state_d = ST_RETRY;
                    end else begin
                        err_idx_d = index_q;
                        state_d   = ST_ERROR;
                    end
                end
            end
            // Retries reuse the latched fields; the table is not read again.
            ST_RETRY: begin
                if (delay_q == 32'd0) state_d = ST_ISSUE;
                else                  delay_d = delay_q - 32'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.busy         = !(state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
    assign bus.done         = (state_q == ST_DONE);
    assign bus.error        = (state_q == ST_ERROR);
    assign bus.error_index  = err_idx_q;
    assign bus.table_index  = index_q;
    assign bus.i2c_ready    = (state_q == ST_ISSUE);
    assign bus.i2c_address  = addr_q;
    assign bus.i2c_rw       = 1'b0;
    assign bus.i2c_register = reg_q;
    assign bus.i2c_data     = data_q;

    a_ready_pulse: assert property (@(posedge clock_i) disable iff (reset_i)
        bus.i2c_ready |=> !bus.i2c_ready);

    a_fields_hold: assert property (@(posedge clock_i) disable iff (reset_i)
        (state_q == ST_WAIT && !bus.i2c_valid) |=> $stable({addr_q, reg_q, data_q}));

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Directed bench for i2c_init_sequencer: a cycle table for the all-ACK run,
// then hand-written retry, error, startup-delay and reset sequences.
module tb_i2c_init_sequencer;
    import i2c_init_sequencer_pkg::*;

    localparam logic [22:0] E0 = {7'h1A, 8'h10, 8'hA5};
    localparam logic [22:0] E1 = {7'h2B, 8'h21, 8'h5A};
    localparam logic [22:0] E2 = {7'h3C, 8'h32, 8'hC3};
    localparam logic [22:0] F0 = {7'h50, 8'h01, 8'h11};
    localparam logic [22:0] F1 = {7'h51, 8'h02, 8'h22};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    i2c_init_sequencer_if bus_a ();
    i2c_init_sequencer_if bus_b ();

    // A: 3 entries, 2 retries, 10-cycle retry gap, no startup delay
    i2c_init_sequencer #(
        .ENTRY_COUNT (3), .RETRY_LIMIT (2), .RETRY_DELAY (10), .STARTUP_DELAY (0),
        .TABLE_INIT  ({E2, E1, E0})
    ) dut_a (.clock_i (clk), .reset_i (rst), .bus (bus_a.master));

    // B: 2 entries, no retries, 2-cycle startup delay
    i2c_init_sequencer #(
        .ENTRY_COUNT (2), .RETRY_LIMIT (0), .RETRY_DELAY (1), .STARTUP_DELAY (2),
        .TABLE_INIT  ({F1, F0})
    ) dut_b (.clock_i (clk), .reset_i (rst), .bus (bus_b.master));

    typedef struct {
        logic        start, valid, ack;
        logic        busy, done, error, ready;
        logic [7:0]  idx;
        logic [22:0] fld;
    } vec_t;

    vec_t vt [18];

    function automatic vec_t mk(input logic s, v, a, b, d, e, r,
                                input logic [7:0] i, input logic [22:0] f);
        vec_t x;
        x.start = s; x.valid = v; x.ack = a;
        x.busy = b; x.done = d; x.error = e; x.ready = r; x.idx = i; x.fld = f;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic s, input logic v, input logic a);
        if (sel) begin
            bus_b.start = s; bus_b.i2c_valid = v; bus_b.i2c_ack = a;
        end else begin
            bus_a.start = s; bus_a.i2c_valid = v; bus_a.i2c_ack = a;
        end
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? bus_b.i2c_ready : bus_a.i2c_ready;
    endfunction

    function automatic logic [22:0] flds(input bit sel);
        return sel ? {bus_b.i2c_address, bus_b.i2c_register, bus_b.i2c_data}
                   : {bus_a.i2c_address, bus_a.i2c_register, bus_a.i2c_data};
    endfunction

    function automatic logic [2:0] stat(input bit sel);
        return sel ? {bus_b.busy, bus_b.done, bus_b.error}
                   : {bus_a.busy, bus_a.done, bus_a.error};
    endfunction

    task automatic kick(input bit sel);
        @(negedge clk); drive(sel, 1'b1, 1'b0, 1'b0);
        @(negedge clk); drive(sel, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_ready(input bit sel, input int limit, output int n);
        n = 0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk); #1;
            if (rdy(sel)) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic expect_issue(input bit sel, input int lat, input logic [22:0] f, input string nm);
        int n;
        wait_ready(sel, 40, n);
        chk({nm, "_latency"}, 32'(n), 32'(lat));
        chk({nm, "_fields"}, 32'(flds(sel)), 32'(f));
        chk({nm, "_rw"}, 32'(sel ? bus_b.i2c_rw : bus_a.i2c_rw), 32'd0);
    endtask

    task automatic respond(input bit sel, input logic ack, input string nm);
        @(negedge clk); drive(sel, 1'b0, 1'b1, ack);
        #1 chk({nm, "_ready_1cyc"}, 32'(rdy(sel)), 32'd0);
        @(negedge clk); drive(sel, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int n;
        drive(0, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0);

        vt[0]  = mk(1,0,0, 0,0,0,0, 8'd0, '0);
        vt[1]  = mk(0,0,0, 1,0,0,0, 8'd0, '0);
        vt[2]  = mk(0,0,0, 1,0,0,0, 8'd0, '0);
        vt[3]  = mk(0,0,0, 1,0,0,1, 8'd0, E0);
        vt[4]  = mk(1,0,0, 1,0,0,0, 8'd0, '0);   // start in WAIT: ignored
        vt[5]  = mk(0,1,0, 1,0,0,0, 8'd0, '0);
        vt[6]  = mk(0,1,1, 1,0,0,0, 8'd1, '0);   // valid in FETCH: ignored
        vt[7]  = mk(0,0,0, 1,0,0,0, 8'd1, '0);
        vt[8]  = mk(0,0,0, 1,0,0,1, 8'd1, E1);
        vt[9]  = mk(0,1,0, 1,0,0,0, 8'd1, '0);
        vt[10] = mk(0,0,0, 1,0,0,0, 8'd2, '0);
        vt[11] = mk(1,0,0, 1,0,0,0, 8'd2, '0);   // start in LOAD: ignored
        vt[12] = mk(0,0,0, 1,0,0,1, 8'd2, E2);
        vt[13] = mk(0,0,0, 1,0,0,0, 8'd2, '0);
        vt[14] = mk(0,1,0, 1,0,0,0, 8'd2, '0);
        vt[15] = mk(0,0,0, 0,1,0,0, 8'd2, '0);
        vt[16] = mk(0,1,1, 0,1,0,0, 8'd2, '0);   // valid in DONE: ignored
        vt[17] = mk(0,0,0, 0,1,0,0, 8'd2, '0);

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_a_status", 32'(stat(0)), 32'd0);
        chk("rst_a_ready", 32'(rdy(0)), 32'd0);
        chk("rst_a_index", 32'(bus_a.table_index), 32'd0);
        chk("rst_b_status", 32'(stat(1)), 32'd0);
        @(negedge clk); rst = 1'b0;

        // All-ACK run, cycle by cycle
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            drive(0, vt[k].start, vt[k].valid, vt[k].ack);
            #1;
            chk($sformatf("tbl%0d_busy", k),  32'(bus_a.busy),        32'(vt[k].busy));
            chk($sformatf("tbl%0d_done", k),  32'(bus_a.done),        32'(vt[k].done));
            chk($sformatf("tbl%0d_error", k), 32'(bus_a.error),       32'(vt[k].error));
            chk($sformatf("tbl%0d_ready", k), 32'(bus_a.i2c_ready),   32'(vt[k].ready));
            chk($sformatf("tbl%0d_index", k), 32'(bus_a.table_index), 32'(vt[k].idx));
            if (vt[k].ready)
                chk($sformatf("tbl%0d_fields", k), 32'(flds(0)), 32'(vt[k].fld));
        end

        // Single NACK on entry 1, retried after exactly 10 idle cycles
        kick(0);
        #1 chk("retry_restart_status", 32'(stat(0)), 32'b100);
        expect_issue(0, 2, E0, "retry_e0");
        respond(0, 1'b0, "retry_e0");
        expect_issue(0, 2, E1, "retry_e1");
        respond(0, 1'b1, "retry_e1_nack");
        expect_issue(0, 10, E1, "retry_e1_again");
        respond(0, 1'b0, "retry_e1_ack");
        expect_issue(0, 2, E2, "retry_e2");
        respond(0, 1'b0, "retry_e2");
        #1 chk("retry_final_status", 32'(stat(0)), 32'b010);

        // Entry 2 always NACKs: three attempts then ERROR
        kick(0);
        expect_issue(0, 2, E0, "err_e0");
        respond(0, 1'b0, "err_e0");
        expect_issue(0, 2, E1, "err_e1");
        respond(0, 1'b0, "err_e1");
        for (int a = 0; a < 3; a++) begin
            expect_issue(0, (a == 0) ? 2 : 10, E2, $sformatf("err_e2_att%0d", a));
            respond(0, 1'b1, $sformatf("err_e2_att%0d", a));
        end
        #1;
        chk("err_status", 32'(stat(0)), 32'b001);
        chk("err_index", 32'(bus_a.error_index), 32'd2);
        wait_ready(0, 20, n);
        chk("err_no_more_attempts", 32'(n), 32'd0);

        // B: startup delay of 2, first NACK is fatal with no retries
        kick(1);
        #1 chk("b_busy_in_startup", 32'(bus_b.busy), 32'd1);
        expect_issue(1, 4, F0, "b_f0");
        respond(1, 1'b1, "b_f0_nack");
        #1;
        chk("b_err_status", 32'(stat(1)), 32'b001);
        chk("b_err_index", 32'(bus_b.error_index), 32'd0);
        kick(1);
        #1 chk("b_restart_clears_error", 32'(stat(1)), 32'b100);
        expect_issue(1, 4, F0, "b_run_f0");
        respond(1, 1'b0, "b_run_f0");
        expect_issue(1, 2, F1, "b_run_f1");
        respond(1, 1'b0, "b_run_f1");
        #1 chk("b_done_status", 32'(stat(1)), 32'b010);

        // Reset while WAITing with a completion in flight
        kick(0);
        expect_issue(0, 2, E0, "rw_pre");
        @(negedge clk); rst = 1'b1; drive(0, 1'b0, 1'b1, 1'b0);
        @(negedge clk); drive(0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("rw_status", 32'(stat(0)), 32'd0);
        chk("rw_ready", 32'(rdy(0)), 32'd0);
        chk("rw_index", 32'(bus_a.table_index), 32'd0);
        chk("rw_err_index", 32'(bus_a.error_index), 32'd0);
        chk("rw_fields", 32'(flds(0)), 32'd0);
        chk("rw_b_status", 32'(stat(1)), 32'd0);
        @(negedge clk); drive(0, 1'b1, 1'b0, 1'b0);
        @(negedge clk); rst = 1'b0; drive(0, 1'b0, 1'b0, 1'b0);
        #1 chk("start_with_reset_ignored", 32'(bus_a.busy), 32'd0);
        kick(0);
        expect_issue(0, 2, E0, "rw_post_e0");
        respond(0, 1'b0, "rw_post_e0");
        expect_issue(0, 2, E1, "rw_post_e1");
        respond(0, 1'b0, "rw_post_e1");
        expect_issue(0, 2, E2, "rw_post_e2");
        respond(0, 1'b0, "rw_post_e2");
        #1 chk("rw_post_done", 32'(stat(0)), 32'b010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
